hcsr04_echo_responder: RTL
==========================

Name: hcsr04_echo_responder

Overview:
Synthesizable HC-SR04 ultrasonic-sensor emulator; it is the responder end of the trig/echo protocol that the design's sensor driver initiates.
- Accepts a trig pulse and, after a fixed burst delay, returns an echo pulse whose width encodes a programmed distance in inches.
- Used on the bench and in hardware loopback (FPGA pin or internal wire) to exercise the sensor/display path without a physical transducer.
- Runs on the 12 MHz system clock.

Parameters:
- CYCLES_PER_INCH, 1776: echo-high clocks per inch of distance (148 us at 12 MHz).
- MIN_TRIG_CYCLES, 120: minimum valid trig-high length (10 us).
- BURST_DELAY_CYCLES, 2400: clocks from accepted trig fall to echo rise (200 us, emulates 8-pulse burst).
- TIMEOUT_CYCLES, 456000: echo width for no-object or overflow (38 ms).
- HOLDOFF_CYCLES, 120000: dead time after echo fall; trig ignored (10 ms).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  1  trigger from initiator; asynchronous, internally double-flop synchronized.
- dist_in  in  8  target distance in inches; sampled once per accepted trig.
- no_echo  in  1  when 1 at sample time, respond with timeout echo.
- echo  out  1  echo pulse, registered.
- busy  out  1  high in any state except IDLE.
- trig_err  out  1  one-cycle pulse on rejected (short) trig.
- resp_count  out  8  count of completed echo pulses, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): echo=0, busy=0, trig_err=0, resp_count=0, FSM=IDLE, synchronizer flops=0, all counters=0.
- trig_s = trig after 2 flops. The edge detector compares trig_s to its previous value.
- FSM states: IDLE, TRIG, DELAY, ECHO, HOLDOFF.
- IDLE: rising edge of trig_s -> TRIG, high-counter cleared to 1.
- TRIG: counter increments while trig_s=1, saturating at MIN_TRIG_CYCLES. On the trig_s falling edge:
  - If count >= MIN_TRIG_CYCLES: latch dist_in and no_echo, compute W, go to DELAY.
  - Otherwise: pulse trig_err for exactly 1 cycle and return to IDLE.
  - Trig held high indefinitely: stay in TRIG; no echo until it falls.
- Width computation W:
  - If no_echo=1: W = TIMEOUT_CYCLES.
  - Otherwise W = max(dist,1) * CYCLES_PER_INCH, computed at 24-bit width, clamped to TIMEOUT_CYCLES if larger. dist_in=0 is treated as 1 inch.
- DELAY: lasts exactly BURST_DELAY_CYCLES cycles, then -> ECHO.
- ECHO: echo=1 for exactly W consecutive cycles. At the end, echo drops on the same edge as the transition to HOLDOFF, and resp_count increments.
- HOLDOFF: lasts exactly HOLDOFF_CYCLES cycles, then -> IDLE.
  - Trig edges are ignored; no trig_err is raised.
  - If trig_s is still high on entering IDLE, no response: a fresh rising edge is required.
- Trig activity during DELAY or ECHO is ignored; the current response completes unchanged.
- dist_in/no_echo changes after the sample point do not affect the in-flight pulse.
- Reset asserted mid-operation: echo falls immediately (async); the in-flight response is abandoned and not counted.
- busy=1 from entry to TRIG through the last HOLDOFF cycle.
- Counters are 24 bits wide. Parameters must satisfy TIMEOUT_CYCLES < 2^24.

Optional Feature:
- ECHO_JITTER_EN defined:
  - An 8-bit maximal LFSR (taps 8,6,5,4, seed 8'hA5 at reset) advances once per accepted trig.
  - Its low 4 bits (0..15) are added to W after clamping, so the final width ≤ TIMEOUT_CYCLES+15.
- Undefined: no LFSR is instantiated; W is exact.

Test Plan:
Bench overrides: CYCLES_PER_INCH=10, MIN_TRIG_CYCLES=4, BURST_DELAY_CYCLES=20, TIMEOUT_CYCLES=3000, HOLDOFF_CYCLES=50, macro undefined.
- Nominal: trig high 6 cycles, dist_in=12 -> echo rises 20 cycles after the FSM sees the trig_s fall, stays high exactly 120 cycles, resp_count 0->1, busy drops 50 cycles after echo fall.
- Short trig: trig high 2 cycles -> trig_err single-cycle pulse, echo stays 0, busy returns 0, resp_count unchanged.
- Timeout/clamp: no_echo=1 -> echo width 3000. Separately dist_in=255 (2550 < 3000) -> width 2550. Separately dist_in=0 -> width 10.
- Holdoff/overlap: second 6-cycle trig during ECHO and a third during HOLDOFF -> exactly one echo pulse, resp_count +1 only. A fourth trig after IDLE -> second pulse.
- Reset mid-echo: assert rst_n=0 at echo cycle 30 -> echo=0 in the same cycle without a clock edge, resp_count=0. After release, a new trig gets a full response.
- Wrap: 256 nominal responses -> resp_count reads 0. With ECHO_JITTER_EN, every width for dist_in=12 lies in 120..135 and the sequence is repeatable from reset.

Source files
------------

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 echo responder: turns an accepted trig into a distance-coded echo.
// Optional `ECHO_JITTER_EN adds 0..15 cycles of LFSR jitter to each echo.
module hcsr04_echo_responder #(
  parameter int unsigned CYCLES_PER_INCH    = 1776,
  parameter int unsigned MIN_TRIG_CYCLES    = 120,
  parameter int unsigned BURST_DELAY_CYCLES = 2400,
  parameter int unsigned TIMEOUT_CYCLES     = 456000,
  parameter int unsigned HOLDOFF_CYCLES     = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic [7:0] dist_in,
  input  logic       no_echo,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic [7:0] resp_count
);

  localparam logic [23:0] CPI   = 24'(CYCLES_PER_INCH);
  localparam logic [23:0] MIN_T = 24'(MIN_TRIG_CYCLES);
  localparam logic [23:0] BURST = 24'(BURST_DELAY_CYCLES);
  localparam logic [23:0] TMO   = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] HOLD  = 24'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {
    IDLE, TRIG, DELAY, ECHO, HOLDOFF
  } state_t;

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [23:0] w, w_n, w_calc;
  logic        trig_m, trig_s, trig_d;
  logic        rise, fall;
  logic        err_n, done, adv;
  logic [7:0]  dist_eff;
  logic [23:0] prod, base;

  assign rise = trig_s & ~trig_d;
  assign fall = ~trig_s & trig_d;
  assign busy = (state != IDLE);

  assign dist_eff = (dist_in == 8'd0) ? 8'd1 : dist_in;
  assign prod     = {16'd0, dist_eff} * CPI;
  assign base     = no_echo      ? TMO :
                    (prod > TMO) ? TMO : prod;

`ifdef ECHO_JITTER_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign w_calc  = base + {20'd0, lfsr[3:0]};

  // Jitter source, stepped once per accepted trig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   lfsr <= 8'hA5;
    else if (adv) lfsr <= {lfsr[6:0], lfsr_fb};
  end
`else
  assign w_calc = base;
`endif

  // Two-flop synchronizer plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_d <= trig_s;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 24'd0;
      w          <= 24'd0;
      echo       <= 1'b0;
      trig_err   <= 1'b0;
      resp_count <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      w          <= w_n;
      echo       <= (state_n == ECHO);
      trig_err   <= err_n;
      resp_count <= resp_count + {7'd0, done};
    end
  end

  // Next-state logic; cnt counts cycles spent in the current phase.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    w_n     = w;
    err_n   = 1'b0;
    done    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = TRIG;
          cnt_n   = 24'd1;
        end
      end
      TRIG: begin
        if (fall) begin
          if (cnt >= MIN_T) begin
            state_n = DELAY;
            cnt_n   = 24'd1;
            w_n     = w_calc;
            adv     = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = 24'd0;
            err_n   = 1'b1;
          end
        end else if (cnt < MIN_T) begin
          cnt_n = cnt + 24'd1;
        end
      end
      DELAY: begin
        if (cnt >= BURST) begin
          state_n = ECHO;
          cnt_n   = 24'd1;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      ECHO: begin
        if (cnt >= w) begin
          state_n = HOLDOFF;
          cnt_n   = 24'd1;
          done    = 1'b1;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      HOLDOFF: begin
        if (cnt >= HOLD) begin
          state_n = IDLE;
          cnt_n   = 24'd0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 24'd0;
      end
    endcase
  end

endmodule
